// File: rtl/lsu_mem_port.sv
// rtl/lsu_mem_port.sv - load/store unit in front of a word-wide data SRAM
//
// Purpose: accepts one load/store request at a time, rejects misaligned,
// illegal-size and out-of-range requests without touching the RAM, turns
// byte/halfword stores into read-modify-write word accesses and returns
// loads with lane extraction and sign/zero extension.
//
// Ports:
//   clk, areset_n           clock (shared with RAM), async active-low reset
//   req_valid / req_ready   request handshake, accepted when both high
//   req_we, req_size,       store flag, size (00 b, 01 h, 10 w, 11 illegal),
//   req_signed, req_addr,   load sign extension, byte address,
//   req_wdata               right-justified store data
//   rsp_valid, rsp_data,    one-cycle response strobe, load result,
//   rsp_err                 error flag qualifying rsp_valid
//   mem_add_r, mem_rd       RAM read address (word aligned) and strobe
//   mem_add_w, mem_data_w,  RAM write address (word aligned), data
//   mem_wr                  and strobe
//   mem_data_r              RAM read data, valid one cycle after mem_rd
module lsu_mem_port #(
  parameter int unsigned adr_limit = 64
) (
  input  logic        clk,
  input  logic        areset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_data,
  output logic        rsp_err,
  output logic [31:0] mem_add_r,
  output logic [31:0] mem_add_w,
  output logic [31:0] mem_data_w,
  output logic        mem_rd,
  output logic        mem_wr,
  input  logic [31:0] mem_data_r
);

  typedef enum logic [3:0] {
    IDLE, ERR, RD, LDRET, WR, RMW_RD, RMW_MERGE, RMW_WR, ACK
  } state_t;

  localparam logic [31:0] addr_max = 32'(adr_limit) << 2;

  state_t      state;
  logic [31:0] addr_q;
  logic [1:0]  size_q;
  logic        signed_q;
  logic [15:0] wdata_q;   // only sub-word stores need the data after acceptance

  logic        req_err;
  logic [7:0]  lane_byte;
  logic [15:0] lane_half;
  logic [31:0] ld_data;
  logic [31:0] merged;

  // A range violation and an alignment violation both yield the same error.
  always_comb begin
    req_err = (req_size == 2'b11)
            | ((req_size == 2'b01) & req_addr[0])
            | ((req_size == 2'b10) & (req_addr[1:0] != 2'b00))
            | (req_addr > addr_max);
  end

  always_comb begin
    lane_byte = mem_data_r[7:0];
    case (addr_q[1:0])
      2'd0: lane_byte = mem_data_r[7:0];
      2'd1: lane_byte = mem_data_r[15:8];
      2'd2: lane_byte = mem_data_r[23:16];
      2'd3: lane_byte = mem_data_r[31:24];
      default: lane_byte = mem_data_r[7:0];
    endcase
    lane_half = addr_q[1] ? mem_data_r[31:16] : mem_data_r[15:0];

    ld_data = mem_data_r;
    case (size_q)
      2'b00: ld_data = {{24{signed_q & lane_byte[7]}}, lane_byte};
      2'b01: ld_data = {{16{signed_q & lane_half[15]}}, lane_half};
      default: ld_data = mem_data_r;
    endcase
  end

  // Replace only the addressed lane(s) of the word just read back.
  always_comb begin
    merged = mem_data_r;
    if (size_q == 2'b00) begin
      merged[8*addr_q[1:0] +: 8] = wdata_q[7:0];
    end else if (addr_q[1]) begin
      merged[31:16] = wdata_q;
    end else begin
      merged[15:0] = wdata_q;
    end
  end

  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      state      <= IDLE;
      req_ready  <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_err    <= 1'b0;
      rsp_data   <= 32'h0;
      mem_rd     <= 1'b0;
      mem_wr     <= 1'b0;
      mem_add_r  <= 32'h0;
      mem_add_w  <= 32'h0;
      mem_data_w <= 32'h0;
      addr_q     <= 32'h0;
      size_q     <= 2'b00;
      signed_q   <= 1'b0;
      wdata_q    <= 16'h0;
    end else begin
      // Response strobe is one cycle wide unless re-armed below.
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_data  <= 32'h0;
      case (state)
        // ERR and ACK are the response cycles; they accept like IDLE.
        IDLE, ERR, ACK: begin
          if (req_valid && req_ready) begin
            addr_q    <= req_addr;
            size_q    <= req_size;
            signed_q  <= req_signed;
            wdata_q   <= req_wdata[15:0];
            req_ready <= 1'b0;
            if (req_err) begin
              state     <= ERR;
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              req_ready <= 1'b1;
            end else if (!req_we) begin
              state     <= RD;
              mem_rd    <= 1'b1;
              mem_add_r <= {req_addr[31:2], 2'b00};
            end else if (req_size == 2'b10) begin
              state      <= WR;
              mem_wr     <= 1'b1;
              mem_add_w  <= {req_addr[31:2], 2'b00};
              mem_data_w <= req_wdata;
            end else begin
              state     <= RMW_RD;
              mem_rd    <= 1'b1;
              mem_add_r <= {req_addr[31:2], 2'b00};
            end
          end else begin
            state     <= IDLE;
            req_ready <= 1'b1;
          end
        end
        RD: begin
          mem_rd <= 1'b0;
          state  <= LDRET;
        end
        LDRET: begin
          rsp_valid <= 1'b1;
          rsp_data  <= ld_data;
          req_ready <= 1'b1;
          state     <= IDLE;
        end
        WR: begin
          mem_wr    <= 1'b0;
          rsp_valid <= 1'b1;
          req_ready <= 1'b1;
          state     <= ACK;
        end
        RMW_RD: begin
          mem_rd <= 1'b0;
          state  <= RMW_MERGE;
        end
        RMW_MERGE: begin
          mem_data_w <= merged;
          mem_add_w  <= {addr_q[31:2], 2'b00};
          mem_wr     <= 1'b1;
          state      <= RMW_WR;
        end
        RMW_WR: begin
          mem_wr    <= 1'b0;
          rsp_valid <= 1'b1;
          req_ready <= 1'b1;
          state     <= ACK;
        end
        default: begin
          mem_rd    <= 1'b0;
          mem_wr    <= 1'b0;
          req_ready <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_mem_port.sv
// tb/tb_lsu_mem_port.sv - scoreboard bench for lsu_mem_port
module tb_lsu_mem_port;

  logic        clk = 1'b0;
  logic        areset_n;
  logic        req_valid, req_ready, req_we, req_signed;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_data;
  logic [31:0] mem_add_r, mem_add_w, mem_data_w, mem_data_r;
  logic        mem_rd, mem_wr;

  always #5 clk = ~clk;

  lsu_mem_port #(.adr_limit(64)) dut (
    .clk(clk), .areset_n(areset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .mem_add_r(mem_add_r), .mem_add_w(mem_add_w), .mem_data_w(mem_data_w),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_data_r(mem_data_r)
  );

  // Word RAM model: read data appears the cycle after the read strobe.
  logic [31:0] ram [0:255];
  always @(posedge clk) begin
    if (mem_wr) ram[mem_add_w[9:2]] <= mem_data_w;
    if (mem_rd) mem_data_r <= ram[mem_add_r[9:2]];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_err = 0;
  logic chk_b2b = 1'b0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail(string name);
    n_checks++;
    n_err++;
    $display("FAIL %s: unexpected event at cycle %0d", name, cyc);
  endtask

  typedef struct { logic [31:0] data; logic err; int due; } rsp_t;
  typedef struct { logic [31:0] addr; logic [31:0] data; int due; } mem_t;
  rsp_t rsp_q[$];
  mem_t rd_q[$];
  mem_t wr_q[$];
  rsp_t er;
  mem_t em;

  // Monitor: every DUT strobe must match the head of its expectation queue.
  always @(negedge clk) begin
    if (areset_n) begin
      if (rsp_valid) begin
        if (rsp_q.size() == 0) fail("rsp_unexpected");
        else begin
          er = rsp_q.pop_front();
          check("rsp_data", rsp_data, er.data);
          check("rsp_err", {31'b0, rsp_err}, {31'b0, er.err});
          check("rsp_cycle", cyc, er.due);
        end
      end
      if (mem_rd) begin
        if (rd_q.size() == 0) fail("mem_rd_unexpected");
        else begin
          em = rd_q.pop_front();
          check("mem_add_r", mem_add_r, em.addr);
          check("mem_rd_cycle", cyc, em.due);
        end
      end
      if (mem_wr) begin
        check("rd_wr_exclusive", {31'b0, mem_rd}, 32'h0);
        if (wr_q.size() == 0) fail("mem_wr_unexpected");
        else begin
          em = wr_q.pop_front();
          check("mem_add_w", mem_add_w, em.addr);
          check("mem_data_w", mem_data_w, em.data);
          check("mem_wr_cycle", cyc, em.due);
        end
      end
    end
  end

  // Drive a request, wait for acceptance, and queue its expected effects.
  // Latencies are counted in cycles after the accepting edge; 0 = none.
  task automatic send(input logic we, input logic [1:0] size, input logic sgn,
                      input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [31:0] exp_data, input logic exp_err,
                      input int rd_lat, input int wr_lat,
                      input logic [31:0] wr_data, input int rsp_lat);
    int n;
    req_valid = 1'b1; req_we = we; req_size = size; req_signed = sgn;
    req_addr = addr; req_wdata = wdata;
    n = 0;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      fail("accept_timeout");
      req_valid = 1'b0;
      return;
    end
    if (chk_b2b) check("b2b_accept_in_rsp_cycle", {31'b0, rsp_valid}, 32'h1);
    if (rd_lat > 0) rd_q.push_back('{addr & ~32'h3, 32'h0, cyc + rd_lat});
    if (wr_lat > 0) wr_q.push_back('{addr & ~32'h3, wr_data, cyc + wr_lat});
    if (rsp_lat > 0) rsp_q.push_back('{exp_data, exp_err, cyc + rsp_lat});
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic st_word(input logic [31:0] addr, input logic [31:0] d);
    send(1'b1, 2'b10, 1'b0, addr, d, 32'h0, 1'b0, 0, 1, d, 2);
  endtask

  task automatic st_sub(input logic [1:0] size, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [31:0] merged);
    send(1'b1, size, 1'b0, addr, wd, 32'h0, 1'b0, 1, 3, merged, 4);
  endtask

  task automatic ld(input logic [1:0] size, input logic sgn,
                    input logic [31:0] addr, input logic [31:0] exp);
    send(1'b0, size, sgn, addr, 32'h0, exp, 1'b0, 1, 0, 32'h0, 3);
  endtask

  task automatic bad(input logic we, input logic [1:0] size, input logic [31:0] addr);
    send(we, size, 1'b0, addr, 32'hFFFF_FFFF, 32'h0, 1'b1, 0, 0, 32'h0, 1);
  endtask

  task automatic idle(input int n);
    req_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic chk_rst(string t);
    check({t, "_req_ready"}, {31'b0, req_ready}, 32'h0);
    check({t, "_rsp_valid"}, {31'b0, rsp_valid}, 32'h0);
    check({t, "_rsp_err"}, {31'b0, rsp_err}, 32'h0);
    check({t, "_mem_rd"}, {31'b0, mem_rd}, 32'h0);
    check({t, "_mem_wr"}, {31'b0, mem_wr}, 32'h0);
    check({t, "_rsp_data"}, rsp_data, 32'h0);
    check({t, "_mem_add_r"}, mem_add_r, 32'h0);
    check({t, "_mem_add_w"}, mem_add_w, 32'h0);
    check({t, "_mem_data_w"}, mem_data_w, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int c;
    areset_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
    req_signed = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
    repeat (3) @(negedge clk);
    chk_rst("reset");
    areset_n = 1'b1;
    #1 check("ready_before_edge", {31'b0, req_ready}, 32'h0);
    @(negedge clk);
    check("ready_after_release", {31'b0, req_ready}, 32'h1);

    // Word store then load
    st_word(32'h10, 32'hDEAD_BEEF); idle(2);
    ld(2'b10, 1'b0, 32'h10, 32'hDEAD_BEEF); idle(2);

    // Byte store read-modify-write and extension
    st_word(32'h10, 32'h1122_3344); idle(2);
    st_sub(2'b00, 32'h11, 32'hFFFF_FF5A, 32'h1122_5A44); idle(2);
    ld(2'b00, 1'b1, 32'h11, 32'h0000_005A); idle(2);
    st_word(32'h10, 32'h80FF_0000); idle(2);
    ld(2'b01, 1'b1, 32'h12, 32'hFFFF_80FF); idle(2);
    ld(2'b01, 1'b0, 32'h12, 32'h0000_80FF); idle(2);
    ld(2'b00, 1'b1, 32'h12, 32'hFFFF_FFFF); idle(2);
    ld(2'b00, 1'b0, 32'h13, 32'h0000_0080); idle(2);
    st_sub(2'b01, 32'h12, 32'h5555_ABCD, 32'hABCD_0000); idle(2);
    st_sub(2'b01, 32'h10, 32'h1111_BEEF, 32'hABCD_BEEF); idle(2);
    ld(2'b10, 1'b0, 32'h10, 32'hABCD_BEEF); idle(2);

    // Errors: no RAM traffic is queued, so any strobe is flagged
    bad(1'b0, 2'b10, 32'h06); idle(2);
    bad(1'b1, 2'b01, 32'h03); idle(2);
    bad(1'b0, 2'b11, 32'h00); idle(2);

    // Range boundary at 4*adr_limit = 0x100
    st_word(32'h100, 32'h1234_5678); idle(2);
    ld(2'b10, 1'b0, 32'h100, 32'h1234_5678); idle(2);
    ld(2'b00, 1'b0, 32'h100, 32'h0000_0078); idle(2);
    bad(1'b0, 2'b10, 32'h104); idle(2);
    bad(1'b0, 2'b00, 32'h101); idle(2);

    // Back-to-back with req_valid held high
    st_word(32'h40, 32'hA5A5_A5A5);
    chk_b2b = 1'b1;
    ld(2'b10, 1'b0, 32'h40, 32'hA5A5_A5A5);
    st_sub(2'b01, 32'h42, 32'h0000_1234, 32'h1234_A5A5);
    ld(2'b10, 1'b0, 32'h40, 32'h1234_A5A5);
    chk_b2b = 1'b0;
    idle(4);

    // Reset during RMW_MERGE aborts the store
    st_word(32'h20, 32'hCAFE_F00D); idle(2);
    send(1'b1, 2'b00, 1'b0, 32'h21, 32'h77, 32'h0, 1'b0, 1, 0, 32'h0, 0);
    c = cyc;
    @(negedge clk);
    check("in_merge_cycle", cyc, c + 1);
    req_valid = 1'b0;
    areset_n = 1'b0;
    #1 chk_rst("abort");
    repeat (2) @(negedge clk);
    areset_n = 1'b1;
    #1 check("abort_ready_before_edge", {31'b0, req_ready}, 32'h0);
    @(negedge clk);
    check("abort_ready_after_edge", {31'b0, req_ready}, 32'h1);
    ld(2'b10, 1'b0, 32'h20, 32'hCAFE_F00D);
    idle(6);

    check("rsp_q_drained", rsp_q.size(), 32'h0);
    check("rd_q_drained", rd_q.size(), 32'h0);
    check("wr_q_drained", wr_q.size(), 32'h0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/lsu_mem_port.md
# lsu_mem_port

Load/store unit sitting directly upstream of the word-wide data SRAM model, between the pipeline's memory stage and that RAM's read/write ports. It accepts one load or store request at a time over a valid/ready handshake and checks alignment and address range before any RAM access. Sub-word stores are turned into read-modify-write word accesses, and loads are returned with byte/halfword extraction and sign/zero extension. Only legal, aligned, in-range word accesses ever reach the RAM, so the RAM's stop/diagnostic path stays silent in normal operation.

## Interface
- adr_limit, 64: highest legal word index; byte address must satisfy req_addr <= 4*adr_limit
- clk  in  1  rising-edge clock, shared with RAM
- areset_n  in  1  asynchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  unit idle, request accepted on clk edge when req_valid & req_ready
- req_we  in  1  1=store, 0=load
- req_size  in  2  00 byte, 01 halfword, 10 word, 11 illegal
- req_signed  in  1  loads only: 1 sign-extend, 0 zero-extend
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-justified
- rsp_valid  out  1  one-cycle response strobe
- rsp_data  out  32  load result; 0 for stores and errors
- rsp_err  out  1  qualifies rsp_valid: misaligned, illegal size or out of range
- mem_add_r  out  32  RAM read address, always word aligned
- mem_add_w  out  32  RAM write address, always word aligned
- mem_data_w  out  32  RAM write data
- mem_rd  out  1  RAM read strobe
- mem_wr  out  1  RAM write strobe
- mem_data_r  in  32  RAM read data, valid the cycle after the read address is presented

## Operation
- All outputs are registered. Lanes are little-endian: lane k = bits [8k+7:8k], k = addr[1:0].
- States: IDLE, CHECK-free error path (ERR), RD, LDRET, WR, RMW_RD, RMW_MERGE, RMW_WR, ACK.
- Acceptance latches addr, size, we, signed and wdata, and clears req_ready.
- Error if size==11, or size==01 with addr[0]=1, or size==10 with addr[1:0]!=0, or addr > 4*adr_limit. Error path: IDLE->ERR. No mem_rd or mem_wr is issued. rsp_err=1, rsp_data=0.
- Load: IDLE->RD->LDRET->IDLE.
  - RD drives mem_rd=1 and mem_add_r={addr[31:2],2'b00}.
  - LDRET selects the lane or halfword (addr[1]) from mem_data_r, then extends it.
- Word store: IDLE->WR->ACK->IDLE.
  - WR drives mem_wr=1, mem_add_w aligned, mem_data_w=wdata.
- Byte/half store: IDLE->RMW_RD->RMW_MERGE->RMW_WR->ACK->IDLE.
  - In RMW_MERGE, the target lane(s) of mem_data_r are replaced by wdata[7:0] or wdata[15:0]. The other bytes are preserved.
- mem_rd and mem_wr are never both 1 in the same cycle. The address outputs hold their last value when idle.
- req_valid deasserted before acceptance is allowed. Request fields are ignored outside the acceptance edge.

## Timing
- Reset (areset_n low, asynchronous): state IDLE. req_ready, rsp_valid, rsp_err, mem_rd and mem_wr are 0. rsp_data, mem_add_r, mem_add_w and mem_data_w are 0.
  - req_ready rises at the first clk edge after deassertion.
- Accept at edge E0 (end of cycle T). Responses:
  - error: rsp_valid in T+1
  - word store: mem_wr in T+1, rsp_valid in T+2
  - load: mem_rd in T+1, rsp_valid in T+3
  - sub-word store: mem_rd in T+1, mem_wr in T+3, rsp_valid in T+4
- rsp_valid is high for exactly one cycle. req_ready rises in the same cycle, so the next request can be accepted at the end of that cycle. There is no overlap between requests.
- Reset asserted mid-operation aborts the operation immediately. No response is issued. A sub-word store aborted before RMW_WR leaves RAM unmodified.
- Boundary: addr=4*adr_limit is legal. addr=4*adr_limit+1 with a byte access is an error. The range check takes precedence only in that both conditions give the same rsp_err=1.

## Test plan
- Reset mid-RMW: assert areset_n low during RMW_MERGE -> all outputs 0 at once, no mem_wr, word unchanged. After release, req_ready=1 one edge later.
- Word store 0xDEADBEEF @0x10, then word load @0x10 -> mem_wr with add_w=0x10 in T+1, rsp_valid in T+2. Load returns 0xDEADBEEF, rsp_err=0, in T+3.
- Byte store 0x5A @0x11 over 0x11223344 -> mem_data_w=0x11225A44 in T+3. Signed byte load @0x11 -> 0x0000005A. Signed half load @0x12 of 0x80FF0000 -> 0xFFFF80FF. Unsigned -> 0x000080FF.
- Misaligned word load @0x06, half store @0x03, size=11 -> rsp_err=1 in T+1, rsp_data=0, no mem_rd or mem_wr asserted.
- Range with adr_limit=64: word load @0x100 -> legal. Word load @0x104 -> rsp_err=1, no RAM access.
- Back-to-back: req_valid held high with three alternating loads and stores -> each accepted in the cycle its predecessor's rsp_valid is high, with no dropped or duplicated responses.
